bram_rr_arbiter: RTL
====================

Name: bram_rr_arbiter

Overview:
- Shares one 256x8 block RAM between two requesters (port 0, port 1) with round-robin arbitration.
- The RAM has a single access slot per cycle: one write or one registered read.
- The read-data register has an asynchronous reset value and a read enable, so the inference flow maps it onto a BRAM output register with arst.
- Sits between two client engines and the shared on-chip buffer.

Parameters:
- AW, 8, address width; depth = 2**AW.
- DW, 8, data width.
- RST_VAL, 8'h5a, asynchronous-reset value of the read-data register.
- INIT_VAL, 8'h3c, power-up (initial) value of the read-data register.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1 each  access request; held until granted.
- we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
- addr0, addr1  input  AW each  access address.
- wdata0, wdata1  input  DW each  write data.
- gnt0, gnt1  output  1 each  combinational grant; the access is performed at this clock edge.
- rvalid0, rvalid1  output  1 each  read data valid for the port, one cycle after a read grant.
- rdata  output  DW  shared registered read data; valid when rvalid0 or rvalid1 is high.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port reset.
- State:
  - last (1 bit): port most recently granted; reset value 1, so port 0 wins first.
  - rvalid0/rvalid1 registers.
  - rdata register.
- Arbitration (combinational):
  - gnt0 = req0 & (~req1 | last==1).
  - gnt1 = req1 & (~req0 | last==0).
  - At most one grant per cycle. A lone requester is granted immediately, with no idle bubble.
- Update on any grant: last <= granted port index. With no grant, last holds.
- Write grant: mem[addr] <= wdata at the edge. rdata is unchanged. No rvalid.
- Read grant:
  - rdata <= mem[addr] at the edge; the read enable is the read grant.
  - The granted port's rvalid is 1 for exactly the next cycle. The other rvalid is 0.
- No read grant: rdata holds its value (no re); rvalid0 = rvalid1 = 0.
- Latency: read data returns 1 cycle after grant.
- Back-to-back: reads on consecutive cycles give one rvalid per cycle. Throughput is 1 access per cycle.
- Read-after-write:
  - A write at cycle N followed by a read of the same address at N+1 returns the new data.
  - Same-cycle conflicts are impossible (single slot).
- Both ports requesting continuously alternate 0,1,0,1…; neither port starves beyond 1 cycle.
- A request dropped before grant is legal and has no effect.
- Reset asserted (asynchronous, any time):
  - rdata = RST_VAL, rvalid0 = rvalid1 = 0, last = 1 immediately.
  - Any in-flight read's rvalid is lost.
  - Memory contents are retained, not reset.
  - Grants are still computed combinationally, but no write or read takes effect while reset is high.
- Power-up, before any reset: rdata = INIT_VAL, last = 1, rvalid = 0.

Optional Feature:
- Macro: BRAM_RR_ARBITER_STATS_EN.
- Defined:
  - Adds outputs gcnt0, gcnt1 (16 bits each): count grants per port. Saturate at 16'hffff. Cleared by reset.
  - Adds output wait_max (8 bits): the longest run of consecutive cycles any port spent requesting without a grant. Saturating, cleared by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package bram_rr_arbiter_pkg holds:
  - AW/DW defaults, RST_VAL and INIT_VAL constants.
  - A port-index typedef (1 bit).
  - A stats-counter width constant (16).
- Sub-module bram_rd_arst: memory array plus registered read port with re, async reset value and init value; one write port. The arbiter instantiates it with re = read grant and we = write grant.

Test Plan:
- Reset: assert reset mid-simulation -> rdata == 8'h5a immediately, rvalid0 = rvalid1 = 0. Before the first reset -> rdata == 8'h3c.
- Single port: port 0 writes 8'hA5 to addr 8'h10, then reads it next cycle -> gnt0 = 1 in both cycles; rvalid0 = 1 one cycle after the read grant; rdata == 8'hA5.
- Contention: req0 and req1 both held high for 6 cycles with reads of addrs 1 and 2 (preloaded 8'h11, 8'h22) -> grants alternate 0,1,0,1,0,1; rdata alternates 11,22,…; rvalid alternates matching the grant one cycle later.
- Idle hold: a read returns 8'h22, then 5 cycles with no requests -> rdata stays 8'h22 and both rvalid stay 0.
- Reset during a read: read granted at edge N, reset pulses between N and N+1 -> rvalid0 = 0 at N+1, rdata == 8'h5a, and the next grant goes to port 0.
- With BRAM_RR_ARBITER_STATS_EN: 3 grants to port 0 and 2 to port 1 -> gcnt0 = 3, gcnt1 = 2. A port blocked for 1 cycle under contention -> wait_max = 1.

Source files
------------

// File: rtl/bram_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin BRAM arbiter.
package bram_rr_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam logic [7:0] RST_VAL_DEF  = 8'h5a;
  localparam logic [7:0] INIT_VAL_DEF = 8'h3c;
  localparam int STAT_W = 16;

  typedef logic port_idx_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bram_rd_arst.sv
// Single-port block RAM with one write port and a registered read port
// whose output register has a read enable, async reset value and power-up value.
module bram_rd_arst
  import bram_rr_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter logic [DW-1:0] RST_VAL  = RST_VAL_DEF,
  parameter logic [DW-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_reg = INIT_VAL;

  // Contents survive reset; only writes are suppressed while it is held.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= RST_VAL;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bram_rr_arbiter.sv
// Two-port round-robin arbiter sharing one block RAM access slot per cycle.
// Define BRAM_RR_ARBITER_STATS_EN to add grant counters and a max-wait monitor.
module bram_rr_arbiter
  import bram_rr_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter logic [DW-1:0] RST_VAL  = RST_VAL_DEF,
  parameter logic [DW-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
`ifdef BRAM_RR_ARBITER_STATS_EN
  output logic [STAT_W-1:0] gcnt0,
  output logic [STAT_W-1:0] gcnt1,
  output logic [7:0]        wait_max,
`endif
  output logic [DW-1:0] rdata
);

  port_idx_t last_reg    = 1'b1;
  logic      rvalid0_reg = 1'b0;
  logic      rvalid1_reg = 1'b0;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // On contention the port that was not granted last wins.
  assign gnt0 = req0 & (~req1 | (last_reg == 1'b1));
  assign gnt1 = req1 & (~req0 | (last_reg == 1'b0));

  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_re    = (gnt0 & ~we0) | (gnt1 & ~we1);
  assign mem_addr  = gnt1 ? addr1 : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_reg    <= 1'b1;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
    end else begin
      if (gnt0 | gnt1) begin
        last_reg <= gnt1;
      end
      rvalid0_reg <= gnt0 & ~we0;
      rvalid1_reg <= gnt1 & ~we1;
    end
  end

  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;

  bram_rd_arst #(
    .AW       (AW),
    .DW       (DW),
    .RST_VAL  (RST_VAL),
    .INIT_VAL (INIT_VAL)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

`ifdef BRAM_RR_ARBITER_STATS_EN
  logic [1:0]              req_v;
  logic [1:0]              gnt_v;
  logic [1:0][STAT_W-1:0]  gcnt_all;
  logic [1:0][7:0]         wait_all_next;
  logic [7:0]              wait_max_reg;
  logic [7:0]              wait_max_next;

  assign req_v = {req1, req0};
  assign gnt_v = {gnt1, gnt0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      logic [STAT_W-1:0] gcnt_reg;
      logic [7:0]        wait_reg;
      logic [7:0]        wait_next;

      // Run length of consecutive requesting-but-not-granted cycles.
      always_comb begin
        wait_next = '0;
        if (req_v[gi] && !gnt_v[gi]) begin
          wait_next = (&wait_reg) ? wait_reg : wait_reg + 8'd1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          gcnt_reg <= '0;
          wait_reg <= '0;
        end else begin
          if (gnt_v[gi]) begin
            gcnt_reg <= sat_inc(gcnt_reg);
          end
          wait_reg <= wait_next;
        end
      end

      assign gcnt_all[gi]      = gcnt_reg;
      assign wait_all_next[gi] = wait_next;
    end
  endgenerate

  always_comb begin
    wait_max_next = wait_max_reg;
    for (int p = 0; p < 2; p++) begin
      if (wait_all_next[p] > wait_max_next) begin
        wait_max_next = wait_all_next[p];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_max_reg <= '0;
    end else begin
      wait_max_reg <= wait_max_next;
    end
  end

  assign gcnt0    = gcnt_all[0];
  assign gcnt1    = gcnt_all[1];
  assign wait_max = wait_max_reg;
`endif

endmodule
